// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with saturating counters, mispredict detection, training and stats
module branch_predict_unit #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         lookup_pc,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
    input  logic                resolve_valid,
    input  logic [31:0]         resolve_pc,
    input  logic                resolve_is_cti,
    input  logic                resolve_taken,
    input  logic [31:0]         resolve_target,
    input  logic                resolve_pred_taken,
    input  logic [31:0]         resolve_pred_target,
    output logic                mispredict,
    output logic [31:0]         redirect_pc,
    output logic [CNT_BITS-1:0] cti_count,
    output logic [CNT_BITS-1:0] miss_count
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = 30 - IDX;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
    logic                valid  [ENTRIES];
    logic [TW-1:0]       tag    [ENTRIES];
    logic [31:0]         target [ENTRIES];
    logic [CTR_BITS-1:0] ctr    [ENTRIES];
    logic [IDX-1:0]      li, ri;
    logic [31:0]         actual;
    logic                r_hit, res_cti, miss;
    always_comb begin
        li          = lookup_pc[IDX+1:2];
        ri          = resolve_pc[IDX+1:2];
        pred_hit    = valid[li] && tag[li] == lookup_pc[31:IDX+2];
        pred_taken  = pred_hit && ctr[li][CTR_BITS-1];
        pred_target = pred_taken ? target[li] : lookup_pc + 32'd4;
        r_hit       = valid[ri] && tag[ri] == resolve_pc[31:IDX+2];
        res_cti     = resolve_valid && resolve_is_cti;
        actual      = resolve_taken ? resolve_target : resolve_pc + 32'd4;
        miss        = resolve_valid && (actual != resolve_pred_target || (!resolve_is_cti && resolve_pred_taken));
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= CTR_WNT;
            end
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            cti_count   <= '0;
            miss_count  <= '0;
        end else begin
            mispredict <= miss;
            if (miss) redirect_pc <= actual;
            if (res_cti && !(&cti_count)) cti_count <= cti_count + CNT_BITS'(1);
            if (miss && !(&miss_count)) miss_count <= miss_count + CNT_BITS'(1);
            if (res_cti && r_hit && resolve_taken) begin
                ctr[ri]    <= &ctr[ri] ? ctr[ri] : ctr[ri] + CTR_BITS'(1);
                target[ri] <= resolve_target;
            end else if (res_cti && r_hit) begin
                ctr[ri] <= |ctr[ri] ? ctr[ri] - CTR_BITS'(1) : ctr[ri];
            end else if (res_cti && resolve_taken) begin
                valid[ri]  <= 1'b1;
                tag[ri]    <= resolve_pc[31:IDX+2];
                target[ri] <= resolve_target;
                ctr[ri]    <= CTR_WT;
            end else if (resolve_valid && !resolve_is_cti && r_hit) begin
                valid[ri] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] lookup_pc = 32'h0040_0010;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        resolve_valid = 1'b0;
    logic [31:0] resolve_pc = '0;
    logic        resolve_is_cti = 1'b0;
    logic        resolve_taken = 1'b0;
    logic [31:0] resolve_target = '0;
    logic        resolve_pred_taken = 1'b0;
    logic [31:0] resolve_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [3:0]  cti_count, miss_count;
    typedef struct {
        logic        m;
        logic [31:0] rd;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int exp_cti = 0;
    int exp_miss = 0;
    branch_predict_unit #(.ENTRIES(16), .CTR_BITS(2), .CNT_BITS(4)) dut (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_is_cti(resolve_is_cti),
        .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .resolve_pred_taken(resolve_pred_taken), .resolve_pred_target(resolve_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .cti_count(cti_count), .miss_count(miss_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic look(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tgt);
        lookup_pc = pc;
        #1;
        chk("pred_hit", 32'(pred_hit), 32'(hit));
        chk("pred_taken", 32'(pred_taken), 32'(tk));
        chk("pred_target", pred_target, tgt);
    endtask
    task automatic drive_res(input logic [31:0] pc, input logic cti, input logic tk, input logic [31:0] tgt,
                             input logic ptk, input logic [31:0] ptgt);
        exp_t e;
        logic [31:0] act;
        resolve_valid = 1'b1;
        resolve_pc = pc;
        resolve_is_cti = cti;
        resolve_taken = tk;
        resolve_target = tgt;
        resolve_pred_taken = ptk;
        resolve_pred_target = ptgt;
        act = tk ? tgt : pc + 32'd4;
        e.m = (act != ptgt) || (!cti && ptk);
        e.rd = act;
        q.push_back(e);
        if (cti && exp_cti < 15) exp_cti++;
        if (e.m && exp_miss < 15) exp_miss++;
    endtask
    task automatic finish_res();
        exp_t e;
        @(posedge clk);
        #1;
        resolve_valid = 1'b0;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk("mispredict", 32'(mispredict), 32'(e.m));
            if (e.m) chk("redirect_pc", redirect_pc, e.rd);
            chk("cti_count", 32'(cti_count), 32'(exp_cti));
            chk("miss_count", 32'(miss_count), 32'(exp_miss));
        end
    endtask
    task automatic resolve(input logic [31:0] pc, input logic cti, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        drive_res(pc, cti, tk, tgt, ptk, ptgt);
        finish_res();
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        look(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_cti", 32'(cti_count), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        resolve(32'h0040_0010, 1, 1, 32'h0040_0040, 0, 32'h0040_0014);
        look(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
        for (int i = 0; i < 3; i++) resolve(32'h0040_0010, 1, 1, 32'h0040_0040, 1, 32'h0040_0040);
        resolve(32'h0040_0010, 1, 0, 32'h0040_0040, 1, 32'h0040_0040);
        look(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
        resolve(32'h0040_0010, 1, 0, 32'h0040_0040, 1, 32'h0040_0040);
        look(32'h0040_0010, 1'b0 | 1'b1, 1'b0, 32'h0040_0014);
        look(32'h0040_1010, 1'b0, 1'b0, 32'h0040_1014);
        resolve(32'h0040_1010, 1, 1, 32'h0040_1100, 0, 32'h0040_1014);
        look(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
        look(32'h0040_1010, 1'b1, 1'b1, 32'h0040_1100);
        lookup_pc = 32'h0040_0020;
        drive_res(32'h0040_0020, 1, 1, 32'h0040_0080, 0, 32'h0040_0024);
        look(32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
        finish_res();
        look(32'h0040_0020, 1'b1, 1'b1, 32'h0040_0080);
        resolve(32'h0040_1010, 0, 0, 32'h0, 1, 32'h0040_1100);
        look(32'h0040_1010, 1'b0, 1'b0, 32'h0040_1014);
        for (int i = 0; i < 14; i++) resolve(32'h0040_0200 + 32'(i * 4), 0, 0, 32'h0, 0, 32'h0);
        resolve(32'h0040_0300, 1, 1, 32'h0040_0400, 0, 32'h0040_0304);
        resolve(32'h0040_0300, 1, 1, 32'h0040_0400, 1, 32'h0040_0400);
        drive_res(32'h0040_0500, 0, 0, 32'h0, 0, 32'h0);
        finish_res();
        reset = 1'b1;
        #1;
        chk("midrst_mispredict", 32'(mispredict), 32'd0);
        chk("midrst_cti", 32'(cti_count), 32'd0);
        chk("midrst_miss", 32'(miss_count), 32'd0);
        look(32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
        look(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
        exp_cti = 0;
        exp_miss = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        resolve(32'h0040_0010, 1, 1, 32'h0040_0040, 0, 32'h0040_0014);
        look(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
        @(posedge clk);
        #1;
        chk("pulse_one_cycle", 32'(mispredict), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
